// File: rtl/spi_master_frame.sv
`default_nettype none
// ============================================================================
// spi_master_frame - SPI mode-0 master, one MSB-first DATA_WIDTH word per frame.
// Rev 1.0
// ============================================================================
module spi_master_frame #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  SCLK_SRC,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  SPI_CS_N,
    output logic                  SPI_SCLK,
    output logic                  SPI_MOSI,
    input  logic                  SPI_MISO
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t                state, state_nx;
    logic                  sclk_q;
    logic                  rise, fall;
    logic [DATA_WIDTH-1:0] tx_sr, tx_sr_nx;
    logic [DATA_WIDTH-1:0] rx_sr, rx_sr_nx;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_nx;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_nx;
    logic                  cs_n_q, cs_n_nx;
    logic                  sclk_out_q, sclk_out_nx;
    logic                  mosi_q, mosi_nx;
    logic                  busy_q, busy_nx;
    logic                  done_q, done_nx;

    // SCLK_SRC is only a timing reference; its edges become one-cycle events.
    assign rise = SCLK_SRC & ~sclk_q;
    assign fall = ~SCLK_SRC & sclk_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            sclk_q     <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_data_q  <= '0;
            bit_cnt    <= '0;
            cs_n_q     <= 1'b1;
            sclk_out_q <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            sclk_q     <= SCLK_SRC;
            tx_sr      <= tx_sr_nx;
            rx_sr      <= rx_sr_nx;
            rx_data_q  <= rx_data_nx;
            bit_cnt    <= bit_cnt_nx;
            cs_n_q     <= cs_n_nx;
            sclk_out_q <= sclk_out_nx;
            mosi_q     <= mosi_nx;
            busy_q     <= busy_nx;
            done_q     <= done_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        tx_sr_nx    = tx_sr;
        rx_sr_nx    = rx_sr;
        rx_data_nx  = rx_data_q;
        bit_cnt_nx  = bit_cnt;
        cs_n_nx     = cs_n_q;
        sclk_out_nx = sclk_out_q;
        mosi_nx     = mosi_q;
        busy_nx     = busy_q;
        done_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (START) begin
                    tx_sr_nx   = TX_DATA;
                    rx_sr_nx   = '0;
                    bit_cnt_nx = '0;
                    cs_n_nx    = 1'b0;
                    mosi_nx    = TX_DATA[DATA_WIDTH-1];
                    busy_nx    = 1'b1;
                    state_nx   = SETUP;
                end
            end
            // Waiting for a fall gives CS_N at least a half-period lead on SCLK.
            SETUP: begin
                if (fall) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (rise) begin
                    sclk_out_nx = 1'b1;
                    rx_sr_nx    = {rx_sr[DATA_WIDTH-2:0], SPI_MISO};
                    bit_cnt_nx  = bit_cnt + CNT_W'(1);
                end else if (fall) begin
                    sclk_out_nx = 1'b0;
                    if (bit_cnt == LAST_BIT) begin
                        state_nx = HOLD;
                    end else begin
                        tx_sr_nx = {tx_sr[DATA_WIDTH-2:0], 1'b0};
                        mosi_nx  = tx_sr[DATA_WIDTH-2];
                    end
                end
            end
            HOLD: begin
                if (fall) begin
                    cs_n_nx    = 1'b1;
                    mosi_nx    = 1'b0;
                    rx_data_nx = rx_sr;
                    done_nx    = 1'b1;
                    state_nx   = GAP;
                end
            end
            GAP: begin
                if (fall) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign RX_DATA  = rx_data_q;
    assign SPI_CS_N = cs_n_q;
    assign SPI_SCLK = sclk_out_q;
    assign SPI_MOSI = mosi_q;

endmodule
`default_nettype wire

// File: doc/spi_master_frame.md
Name: spi_master_frame

Overview:
- Single-channel SPI master (mode 0: CPOL=0, CPHA=0; MSB first) that serialises one DATA_WIDTH-bit word per frame.
- Sits directly downstream of the slow SPI clock generator. It consumes that generator's free-running divided clock (synchronous to CLK) as a timing reference, not as a clock.
- All logic runs on CLK. SPI_SCLK is a registered output regenerated from edge events on SCLK_SRC.
- Provides a START/BUSY/DONE handshake to the upstream control logic.

Parameters:
- DATA_WIDTH, 16, bits per frame (2..32).

Ports:
- CLK  input  1  system clock
- RST_N  input  1  asynchronous active-low reset
- SCLK_SRC  input  1  divided clock from slow clock generator; CLK-domain register, 50% duty
- START  input  1  request a frame; sampled only in IDLE
- TX_DATA  input  DATA_WIDTH  word to transmit; latched on accepted START
- BUSY  output  1  high from the cycle after START acceptance until return to IDLE
- DONE  output  1  one-cycle pulse at end of frame; RX_DATA valid in the same cycle
- RX_DATA  output  DATA_WIDTH  last received word; held until next DONE
- SPI_CS_N  output  1  chip select, active low
- SPI_SCLK  output  1  serial clock, idle low
- SPI_MOSI  output  1  serial data out
- SPI_MISO  input  1  serial data in; the board guarantees it is stable around SCLK rising edges, so no synchroniser is needed

Behaviour:

Reset (async, RST_N low) and outputs:
- Reset values: BUSY=0, DONE=0, RX_DATA=0, SPI_CS_N=1, SPI_SCLK=0, SPI_MOSI=0.
- Reset also clears the state register, shift registers, bit counter and sclk_q.
- Reset mid-frame aborts immediately: no DONE, and RX_DATA is cleared.

Edge detection:
- sclk_q is SCLK_SRC registered once.
- rise = SCLK_SRC & !sclk_q; fall = !SCLK_SRC & sclk_q.
- Each event is exactly one CLK cycle wide. SCLK_SRC toggling every CLK cycle (divider half-period 1) must still work.

FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - Outputs: CS_N=1, SCLK=0, MOSI=0, BUSY=0.
  - START=1 → latch TX_DATA into tx_sr, clear rx_sr and bit counter, go to SETUP.
  - START has no effect in any other state; it is not queued.
- SETUP:
  - CS_N=0 and MOSI=tx_sr[MSB], both registered, on entry (one cycle after acceptance). BUSY=1.
  - Wait for the next fall event, then go to SHIFT. This guarantees CS_N-to-first-SCLK-rise of at least one half-period.
- SHIFT, on rise:
  - SPI_SCLK←1.
  - rx_sr←{rx_sr[DATA_WIDTH-2:0], SPI_MISO}.
  - bit counter +1.
- SHIFT, on fall:
  - SPI_SCLK←0.
  - If counter==DATA_WIDTH, go to HOLD with MOSI unchanged.
  - Otherwise tx_sr shifts left by 1 and MOSI←new MSB.
- HOLD:
  - SCLK=0, CS_N=0.
  - On the next fall: CS_N←1, MOSI←0, RX_DATA←rx_sr, DONE←1 for one cycle, go to GAP.
- GAP:
  - CS_N=1, BUSY=1.
  - On the next fall: BUSY←0, go to IDLE.
  - This guarantees CS_N high for at least one full SCLK_SRC period between frames.
- Rise and fall cannot coincide. Events arriving in states that do not use them are ignored.

Widths and timing:
- Bit counter width is $clog2(DATA_WIDTH+1). It never wraps within a frame.
- Exactly DATA_WIDTH SPI_SCLK rising edges occur per frame.
- SPI_SCLK period = SCLK_SRC period, lagging by 1 CLK cycle.

Stall:
- If SCLK_SRC stops, the FSM holds its state indefinitely and outputs stay stable.

Test Plan:
- Reset: assert RST_N=0 mid-idle and with random inputs → BUSY=0, DONE=0, RX_DATA=0, CS_N=1, SCLK=0, MOSI=0 asynchronously.
- Loopback (SCLK_SRC from the 50 MHz/2.5 MHz generator, toggling every 10 CLK cycles; MISO=MOSI), START with TX_DATA=0xA5C3 →
  - exactly 16 SCLK rises;
  - MOSI sampled at rises reads 1010_0101_1100_0011;
  - DONE one cycle with RX_DATA=0xA5C3;
  - CS_N low to first SCLK rise ≥10 CLK cycles;
  - BUSY low ≥10 cycles after DONE.
- Constant MISO: MISO=1 with TX 0x0000 → RX_DATA=0xFFFF and MOSI never high. MISO=0 with TX 0xFFFF → RX_DATA=0x0000.
- START while BUSY: second START with TX_DATA=0x1234 at bit 5 → frame completes with 0xA5C3 on MOSI, one DONE only, no second frame.
- Back-to-back: START held high continuously → frames separated by CS_N high ≥20 CLK cycles (one full SCLK_SRC period). Each frame sends the TX_DATA present at its acceptance (0x0001, then 0x8000).
- Reset after 5 SCLK rises → all outputs idle at once, no DONE. A following frame with 0x5A5A loops back correctly. Repeat with SCLK_SRC toggling every CLK cycle and expect the same RX results.
